mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single DPI memory port between instruction fetch (IFU) and load/store (LSU).
//  Accepts one request at a time, drives it to the memory side with a valid/ready handshake,
//  waits for the response and routes it back to the owner. LSU has priority; a streak
//  counter bounds IFU starvation. Sits between the IFU/LSU and the DPI memory wrapper.
// PARAMETERS
//  ADDR_W          64  address width
//  DATA_W          64  read/write data width
//  LEN_W            8  write length field width (bytes, matches DPI len)
//  MAX_LSU_STREAK   4  consecutive LSU grants allowed while IFU is waiting (>=1)
// PORTS
//  iClock         in   1        clock, all state on rising edge
//  iReset         in   1        synchronous, active-high reset
//  iIfuReqValid   in   1        IFU fetch request
//  oIfuReqReady   out  1        IFU request accepted this cycle
//  iIfuReqAddr    in   ADDR_W   fetch address
//  oIfuRespValid  out  1        fetch data valid (1-cycle pulse)
//  oIfuRespData   out  DATA_W   fetched data
//  iLsuReqValid   in   1        LSU request
//  oLsuReqReady   out  1        LSU request accepted this cycle
//  iLsuReqWrEn    in   1        1=store, 0=load
//  iLsuReqAddr    in   ADDR_W   load/store address
//  iLsuReqWrData  in   DATA_W   store data
//  iLsuReqWrLen   in   LEN_W    store length in bytes
//  oLsuRespValid  out  1        load data / store ack (1-cycle pulse)
//  oLsuRespData   out  DATA_W   load data (don't-care for stores)
//  oMemReqValid   out  1        request to memory side
//  iMemReqReady   in   1        memory side accepts request
//  oMemReqWrEn    out  1        latched write enable
//  oMemReqAddr    out  ADDR_W   latched address
//  oMemReqWrData  out  DATA_W   latched write data
//  oMemReqWrLen   out  LEN_W    latched write length
//  iMemRespValid  in   1        memory response (1-cycle pulse)
//  iMemRespData   in   DATA_W   memory read data
//  oBusy          out  1        state != IDLE
//  oProtoErr      out  1        sticky: iMemRespValid seen outside RESP
// BEHAVIOUR
//  - Reset: state=IDLE, owner=IFU, lsuStreak=0, all latched req regs=0, oProtoErr=0;
//    hence all valid/ready outputs 0, oMemReq* = 0. Reset mid-transaction drops it silently.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//    IDLE: grant computed combinationally; winner's oXReqReady=1; on accept latch
//      addr/wrEn/wrData/wrLen (IFU: wrEn=0, wrData=0, wrLen=0) and owner; go REQ.
//    REQ: oMemReqValid=1, fields stable; on iMemReqReady go RESP.
//    RESP: on iMemRespValid: owner's oXRespValid=1 same cycle, oXRespData=iMemRespData
//      (combinational pass-through); go IDLE. Other requester's RespValid stays 0.
//  - Readys are 0 outside IDLE; at most one of oIfuReqReady/oLsuReqReady high per cycle.
//  - Min latency: accept cycle N, oMemReqValid cycle N+1, response earliest N+2;
//    next accept earliest the cycle after the response (one transaction outstanding).
//  - Grant: LSU only -> LSU; IFU only -> IFU; both -> LSU unless lsuStreak==MAX_LSU_STREAK,
//    then IFU.
//  - lsuStreak (saturating, clog2(MAX_LSU_STREAK+1) bits), updated on accept only:
//    LSU granted while iIfuReqValid=1 -> +1; LSU granted with IFU idle -> 0; IFU granted -> 0.
//  - iMemRespValid in IDLE or REQ: ignored (no RespValid), oProtoErr set until reset.
//  - iMemReqReady outside REQ ignored. Requesters must hold fields only until their Ready.
// TESTING
//  - Reset: iReset=1 two cycles -> all outputs 0, oBusy=0, oProtoErr=0.
//  - IFU fetch 0x80000000, iMemReqReady=1, resp 1 cycle later data 0x00100073 ->
//    oIfuRespValid pulse with 0x00100073, oLsuRespValid=0, oBusy back to 0.
//  - Store addr 0x80001000 data 0xDEADBEEF len 4 -> oMemReqWrEn=1, fields held while
//    iMemReqReady=0 for 3 cycles; ack -> oLsuRespValid pulse.
//  - Both valid every cycle, MAX_LSU_STREAK=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU...
//  - iMemRespValid pulse while IDLE -> no RespValid, oProtoErr=1 and stays 1 until reset.
//  - iReset in RESP state -> IDLE next cycle; later response ignored and sets oProtoErr.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between IFU and LSU, one transaction outstanding.
// LSU wins ties; a bounded streak counter guarantees IFU forward progress.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int LEN_W          = 8,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iIfuReqValid,
  output logic              oIfuReqReady,
  input  logic [ADDR_W-1:0] iIfuReqAddr,
  output logic              oIfuRespValid,
  output logic [DATA_W-1:0] oIfuRespData,
  input  logic              iLsuReqValid,
  output logic              oLsuReqReady,
  input  logic              iLsuReqWrEn,
  input  logic [ADDR_W-1:0] iLsuReqAddr,
  input  logic [DATA_W-1:0] iLsuReqWrData,
  input  logic [LEN_W-1:0]  iLsuReqWrLen,
  output logic              oLsuRespValid,
  output logic [DATA_W-1:0] oLsuRespData,
  output logic              oMemReqValid,
  input  logic              iMemReqReady,
  output logic              oMemReqWrEn,
  output logic [ADDR_W-1:0] oMemReqAddr,
  output logic [DATA_W-1:0] oMemReqWrData,
  output logic [LEN_W-1:0]  oMemReqWrLen,
  input  logic              iMemRespValid,
  input  logic [DATA_W-1:0] iMemRespData,
  output logic              oBusy,
  output logic              oProtoErr
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_lsu;
  logic [SW-1:0]     r_streak;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [LEN_W-1:0]  r_wr_len;
  logic              r_proto_err;
  logic              w_grant_lsu;
  logic              w_grant_ifu;
  logic              w_resp_fire;

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant_lsu = 1'b0;
    w_grant_ifu = 1'b0;
    w_resp_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        // IFU only overrides LSU once the LSU has used up its streak allowance.
        w_grant_lsu = iLsuReqValid && !(iIfuReqValid && (r_streak == STREAK_MAX));
        w_grant_ifu = iIfuReqValid && !w_grant_lsu;
        if (w_grant_lsu || w_grant_ifu) w_next = S_REQ;
      end
      S_REQ: begin
        if (iMemReqReady) w_next = S_RESP;
      end
      S_RESP: begin
        if (iMemRespValid) begin
          w_resp_fire = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_owner_lsu <= 1'b0;
      r_streak    <= '0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_len    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_grant_lsu) begin
        r_owner_lsu <= 1'b1;
        r_wr_en     <= iLsuReqWrEn;
        r_addr      <= iLsuReqAddr;
        r_wr_data   <= iLsuReqWrData;
        r_wr_len    <= iLsuReqWrLen;
        if (!iIfuReqValid)              r_streak <= '0;
        else if (r_streak != STREAK_MAX) r_streak <= r_streak + SW'(1);
      end else if (w_grant_ifu) begin
        r_owner_lsu <= 1'b0;
        r_wr_en     <= 1'b0;
        r_addr      <= iIfuReqAddr;
        r_wr_data   <= '0;
        r_wr_len    <= '0;
        r_streak    <= '0;
      end
      if (iMemRespValid && (r_state != S_RESP)) r_proto_err <= 1'b1;
    end
  end

  assign oIfuReqReady  = w_grant_ifu;
  assign oLsuReqReady  = w_grant_lsu;
  assign oIfuRespValid = w_resp_fire && !r_owner_lsu;
  assign oLsuRespValid = w_resp_fire && r_owner_lsu;
  assign oIfuRespData  = oIfuRespValid ? iMemRespData : '0;
  assign oLsuRespData  = oLsuRespValid ? iMemRespData : '0;
  assign oMemReqValid  = (r_state == S_REQ);
  assign oMemReqWrEn   = r_wr_en;
  assign oMemReqAddr   = r_addr;
  assign oMemReqWrData = r_wr_data;
  assign oMemReqWrLen  = r_wr_len;
  assign oBusy         = (r_state != S_IDLE);
  assign oProtoErr     = r_proto_err;

endmodule
